eq_coeff_scheduler: RTL and testbench
=====================================

EQ_COEFF_SCHEDULER -- requirements
Module: eq_coeff_scheduler

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- AVG_LEN, 8: accepted frequency samples averaged per acquisition, range 1..64.
- REFRESH_CYCLES, 1024: cycles spent in TRACK before re-acquisition, at least 1.
- MAX_REJECT, 16: out-of-range samples per acquisition that force FAULT.
- FREQ_MIN, 1.0e9: lowest accepted frequency in Hz (real).
- FREQ_MAX, 5.0e10: highest accepted frequency in Hz (real).
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: asynchronous active-high reset.
- enable, input, 1: run request.
- freq_valid, input, 1: freq_in is valid this cycle.
- freq_in, input, real: channel frequency estimate in Hz.
- c1, output, real: equalizer u[n-1] coefficient.
- c2, output, real: equalizer u[n-2] coefficient.
- coef_valid, output, 1: one-cycle pulse when c1 and c2 are updated.
- locked, output, 1: coefficients were derived from a completed acquisition.
- busy, output, 1: state is ACQUIRE or APPLY.
- fault, output, 1: state is FAULT.
- state_o, output, 3: state encoding; IDLE=0, ACQUIRE=1, APPLY=2, TRACK=3, FAULT=4.

Function
REQ-004 The FSM SHALL have the states IDLE, ACQUIRE, APPLY, TRACK and FAULT.
REQ-005 When enable=0, the next state SHALL be IDLE from any state; this has priority over all other events, including a same-cycle freq_valid.
REQ-006 IDLE SHALL go to ACQUIRE when enable=1, clearing the accumulator, sample_cnt and reject_cnt.
REQ-007 In ACQUIRE, a sample with freq_valid=1 and FREQ_MIN<=freq_in<=FREQ_MAX SHALL be added to the real accumulator and SHALL increment sample_cnt.
REQ-008 In ACQUIRE, a sample with freq_valid=1 outside that range SHALL be discarded and SHALL increment reject_cnt.
REQ-009 Range boundaries SHALL be inclusive.
REQ-010 When reject_cnt reaches MAX_REJECT, the FSM SHALL go to FAULT; the reject check SHALL take priority over completion in the same cycle.
REQ-011 At the edge that accepts the AVG_LEN-th sample, the state SHALL become APPLY and f_avg SHALL be latched as accumulator/AVG_LEN.
REQ-012 In APPLY, the next edge SHALL:
- set c1 = 0.0425434079 + 6019033046.3/f_avg;
- set c2 = 0.0337683818 - 6019033046.3/f_avg;
- set coef_valid=1 and locked=1;
- load the refresh counter with REFRESH_CYCLES and enter TRACK.
REQ-013 coef_valid SHALL return to 0 on the following edge; end-to-end latency is 2 edges from the last accepted sample to coef_valid high.
REQ-014 In TRACK, the refresh counter SHALL decrement each cycle; on reaching 0, the FSM SHALL enter ACQUIRE with cleared counters.
REQ-015 freq_valid SHALL be ignored in IDLE, APPLY, TRACK and FAULT.
REQ-016 c1 and c2 SHALL hold their values in every state except the APPLY exit, including through IDLE and FAULT.
REQ-017 locked SHALL clear on entry to IDLE or FAULT and SHALL stay 1 during re-acquisition from TRACK.
REQ-018 FAULT SHALL be exited only via enable=0 (to IDLE).
REQ-019 Division SHALL occur only on a validated f_avg>=FREQ_MIN, so division by zero is impossible.

Reset
REQ-020 While rst=1, asynchronously:
- state=IDLE;
- counters and accumulator 0;
- c1=0.6444467125 and c2=-0.5681349228 (nominal 10 GHz);
- coef_valid=0, locked=0, busy=0, fault=0.
REQ-021 rst asserted mid-ACQUIRE or mid-TRACK SHALL discard the partial average, with no coef_valid pulse.

Verification
REQ-022 The bench SHALL cover these scenarios with AVG_LEN=4:
- Happy path: enable=1, then four valid 1.0e10 samples -> coef_valid pulses exactly 2 edges after the 4th sample; c1≈0.6444467, c2≈-0.5681349; locked=1; state TRACK.
- Mixed samples: samples 1e10, 3e10, 2e10, 2e10 (mean 2e10) -> c1≈0.3434951, c2≈-0.2671833; one coef_valid pulse.
- Reject and fault: with MAX_REJECT=2, samples 6e10, 2e10, 0.5e9 -> the 2e10 sample is accepted and the FSM enters FAULT after the third sample; fault=1, locked=0, c1/c2 unchanged; enable=0 -> IDLE next edge.
- Refresh: with REFRESH_CYCLES=5 after lock -> ACQUIRE entered 5 cycles after TRACK entry; locked stays 1; the new average 2e10 updates c1/c2 with a new pulse.
- Priority: enable=0 in the same cycle as the 4th sample -> IDLE, no coef_valid, c1/c2 unchanged.
- Mid-acquisition reset: rst pulse after 2 samples -> all outputs at reset values immediately; a re-run needs a full 4 new samples.

Source files
------------

// File: rtl/eq_coeff_scheduler.sv
// Acquisition/refresh scheduler for a two-tap equalizer: averages valid channel
// frequency estimates, derives c1/c2 from the mean, then tracks and re-acquires.
module eq_coeff_scheduler #(
  parameter int unsigned AVG_LEN        = 8,
  parameter int unsigned REFRESH_CYCLES = 1024,
  parameter int unsigned MAX_REJECT     = 16,
  parameter real         FREQ_MIN       = 1.0e9,
  parameter real         FREQ_MAX       = 5.0e10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       freq_valid,
  input  real        freq_in,
  output real        c1,
  output real        c2,
  output logic       coef_valid,
  output logic       locked,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state_o
);

  localparam int unsigned SCNT_W = $clog2(AVG_LEN + 1);
  localparam int unsigned RCNT_W = $clog2(MAX_REJECT + 1);
  localparam int unsigned REF_W  = $clog2(REFRESH_CYCLES + 1);

  localparam real C1_OFS = 0.0425434079;
  localparam real C2_OFS = 0.0337683818;
  localparam real K_NUM  = 6019033046.3;
  localparam real C1_RST = 0.6444467125;
  localparam real C2_RST = -0.5681349228;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACQUIRE = 3'd1,
    S_APPLY   = 3'd2,
    S_TRACK   = 3'd3,
    S_FAULT   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  real               acc_q, acc_d;
  real               favg_q, favg_d;
  real               c1_q, c1_d;
  real               c2_q, c2_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic [REF_W-1:0]  refr_q, refr_d;
  logic              cv_q, cv_d;
  logic              locked_q, locked_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;
  logic              in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= 0.0;
      favg_q   <= 0.0;
      c1_q     <= C1_RST;
      c2_q     <= C2_RST;
      scnt_q   <= '0;
      rcnt_q   <= '0;
      refr_q   <= '0;
      cv_q     <= 1'b0;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      favg_q   <= favg_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      scnt_q   <= scnt_d;
      rcnt_q   <= rcnt_d;
      refr_q   <= refr_d;
      cv_q     <= cv_d;
      locked_q <= locked_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
    end
  end

  // Next-state and datapath; enable=0 overrides every other event.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    favg_d   = favg_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    scnt_d   = scnt_q;
    rcnt_d   = rcnt_q;
    refr_d   = refr_q;
    cv_d     = 1'b0;
    locked_d = locked_q;
    in_range = (freq_in >= FREQ_MIN) && (freq_in <= FREQ_MAX);

    if (!enable) begin
      state_d  = S_IDLE;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ACQUIRE;
          acc_d   = 0.0;
          scnt_d  = '0;
          rcnt_d  = '0;
        end
        S_ACQUIRE: begin
          if (freq_valid) begin
            if (!in_range) begin
              rcnt_d = rcnt_q + RCNT_W'(1);
              if (rcnt_q == RCNT_W'(MAX_REJECT - 1)) begin
                state_d  = S_FAULT;
                locked_d = 1'b0;
              end
            end else begin
              acc_d  = acc_q + freq_in;
              scnt_d = scnt_q + SCNT_W'(1);
              if (scnt_q == SCNT_W'(AVG_LEN - 1)) begin
                state_d = S_APPLY;
                favg_d  = acc_d / real'(AVG_LEN);
              end
            end
          end
        end
        S_APPLY: begin
          // Mean of in-range samples is always >= FREQ_MIN; guard keeps the divide safe.
          if (favg_q >= FREQ_MIN) begin
            c1_d = C1_OFS + K_NUM / favg_q;
            c2_d = C2_OFS - K_NUM / favg_q;
          end
          cv_d     = 1'b1;
          locked_d = 1'b1;
          refr_d   = REF_W'(REFRESH_CYCLES);
          state_d  = S_TRACK;
        end
        S_TRACK: begin
          refr_d = refr_q - REF_W'(1);
          if (refr_q <= REF_W'(1)) begin
            state_d = S_ACQUIRE;
            acc_d   = 0.0;
            scnt_d  = '0;
            rcnt_d  = '0;
          end
        end
        S_FAULT: ;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d  = (state_d == S_ACQUIRE) || (state_d == S_APPLY);
    fault_d = (state_d == S_FAULT);
  end

  assign c1         = c1_q;
  assign c2         = c2_q;
  assign coef_valid = cv_q;
  assign locked     = locked_q;
  assign busy       = busy_q;
  assign fault      = fault_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_eq_coeff_scheduler.sv
// Self-checking bench for eq_coeff_scheduler: directed scenarios followed by
// randomized traffic, all checked against a sample-queue reference model.
module tb_eq_coeff_scheduler;

  localparam int unsigned AVG_LEN        = 4;
  localparam int unsigned REFRESH_CYCLES = 5;
  localparam int unsigned MAX_REJECT     = 2;
  localparam real         FREQ_MIN       = 1.0e9;
  localparam real         FREQ_MAX       = 5.0e10;

  localparam int ST_IDLE = 0, ST_ACQ = 1, ST_APPLY = 2, ST_TRACK = 3, ST_FAULT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       freq_valid = 1'b0;
  real        freq_in = 0.0;
  real        c1, c2;
  logic       coef_valid, locked, busy, fault;
  logic [2:0] state_o;

  int vectors = 0;
  int miscompares = 0;

  eq_coeff_scheduler #(
    .AVG_LEN(AVG_LEN), .REFRESH_CYCLES(REFRESH_CYCLES), .MAX_REJECT(MAX_REJECT),
    .FREQ_MIN(FREQ_MIN), .FREQ_MAX(FREQ_MAX)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .freq_valid(freq_valid), .freq_in(freq_in),
    .c1(c1), .c2(c2), .coef_valid(coef_valid), .locked(locked), .busy(busy),
    .fault(fault), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference model: spec-level state plus a queue of accepted samples.
  int  m_state;
  real m_samples[$];
  int  m_rejects;
  int  m_refresh;
  real m_favg;
  real m_c1, m_c2;
  bit  m_cv, m_locked;

  task automatic check(input string tag, input real got, input real exp);
    real d;
    vectors++;
    d = got - exp;
    if (d < 0.0) d = -d;
    if (d > 1.0e-9 * (1.0 + (exp < 0.0 ? -exp : exp))) begin
      miscompares++;
      $display("FAIL %s: got %0.10f expected %0.10f at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ok_freq(input real f);
    return (f >= FREQ_MIN) && (f <= FREQ_MAX);
  endfunction

  task automatic model_reset();
    m_state = ST_IDLE;
    m_samples.delete();
    m_rejects = 0;
    m_refresh = 0;
    m_favg = 0.0;
    m_c1 = 0.6444467125;
    m_c2 = -0.5681349228;
    m_cv = 0;
    m_locked = 0;
  endtask

  task automatic model_step(input bit en, input bit fv, input real f);
    real sum;
    m_cv = 0;
    if (!en) begin
      m_state = ST_IDLE;
      m_locked = 0;
      return;
    end
    case (m_state)
      ST_IDLE: begin
        m_state = ST_ACQ;
        m_samples.delete();
        m_rejects = 0;
      end
      ST_ACQ: if (fv) begin
        if (ok_freq(f)) begin
          m_samples.push_back(f);
          if (m_samples.size() == AVG_LEN) begin
            sum = 0.0;
            foreach (m_samples[i]) sum += m_samples[i];
            m_favg = sum / AVG_LEN;
            m_state = ST_APPLY;
          end
        end else begin
          m_rejects++;
          if (m_rejects == MAX_REJECT) begin
            m_state = ST_FAULT;
            m_locked = 0;
          end
        end
      end
      ST_APPLY: begin
        m_c1 = 0.0425434079 + 6019033046.3 / m_favg;
        m_c2 = 0.0337683818 - 6019033046.3 / m_favg;
        m_cv = 1;
        m_locked = 1;
        m_refresh = REFRESH_CYCLES;
        m_state = ST_TRACK;
      end
      ST_TRACK: begin
        m_refresh--;
        if (m_refresh == 0) begin
          m_state = ST_ACQ;
          m_samples.delete();
          m_rejects = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("state", real'(state_o), real'(m_state));
    check("coef_valid", real'(coef_valid), real'(m_cv));
    check("locked", real'(locked), real'(m_locked));
    check("busy", real'(busy), real'((m_state == ST_ACQ || m_state == ST_APPLY) ? 1 : 0));
    check("fault", real'(fault), real'((m_state == ST_FAULT) ? 1 : 0));
    check("c1", c1, m_c1);
    check("c2", c2, m_c2);
  endtask

  // Called at a negedge: drive, clock once, update model, compare at next negedge.
  task automatic step(input bit en, input bit fv, input real f);
    enable = en;
    freq_valid = fv;
    freq_in = f;
    @(posedge clk);
    model_step(en, fv, f);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset from a negedge; outputs must change before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    compare_all();
    check("rst_c1_nominal", c1, 0.6444467125);
    check("rst_c2_nominal", c2, -0.5681349228);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic real rand_freq();
    int unsigned sel;
    sel = $urandom_range(0, 15);
    case (sel)
      0: return 1.0e9;
      1: return 5.0e10;
      2: return 0.9999e9;
      3: return 5.00001e10;
      default: return real'($urandom_range(1000, 50000)) * 1.0e6;
    endcase
  endfunction

  initial begin
    real mixed[4];
    mixed[0] = 1.0e10; mixed[1] = 3.0e10; mixed[2] = 2.0e10; mixed[3] = 2.0e10;
    @(negedge clk);
    do_reset();

    // Happy path: four 10 GHz samples, pulse two edges after the last one.
    step(1, 0, 0.0);
    for (int i = 0; i < 4; i++) step(1, 1, 1.0e10);
    check("hp_no_pulse_yet", real'(coef_valid), 0.0);
    check("hp_apply", real'(state_o), real'(ST_APPLY));
    step(1, 1, 3.0e10);
    check("hp_pulse", real'(coef_valid), 1.0);
    check("hp_c1", c1, 0.0425434079 + 0.60190330463);
    check("hp_c2", c2, 0.0337683818 - 0.60190330463);
    check("hp_locked", real'(locked), 1.0);
    check("hp_track", real'(state_o), real'(ST_TRACK));
    step(1, 0, 0.0);
    check("hp_pulse_end", real'(coef_valid), 0.0);

    // Refresh: re-acquire after 5 TRACK cycles, locked held, mixed samples mean 2e10.
    for (int i = 0; i < 4; i++) step(1, 1, 4.0e10);
    check("rf_reacquire", real'(state_o), real'(ST_ACQ));
    check("rf_locked", real'(locked), 1.0);
    for (int i = 0; i < 4; i++) step(1, 1, mixed[i]);
    step(1, 0, 0.0);
    check("mx_pulse", real'(coef_valid), 1.0);
    check("mx_c1", c1, 0.0425434079 + 0.300951652315);
    check("mx_c2", c2, 0.0337683818 - 0.300951652315);

    // Reject and fault during re-acquisition.
    for (int i = 0; i < 5; i++) step(1, 0, 0.0);
    check("rj_acq", real'(state_o), real'(ST_ACQ));
    step(1, 1, 6.0e10);
    step(1, 1, 2.0e10);
    step(1, 1, 0.5e9);
    check("rj_fault", real'(fault), 1.0);
    check("rj_unlocked", real'(locked), 0.0);
    check("rj_c1_held", c1, 0.0425434079 + 0.300951652315);
    step(1, 1, 2.0e10);
    check("rj_stays_fault", real'(state_o), real'(ST_FAULT));
    step(0, 0, 0.0);
    check("rj_idle", real'(state_o), real'(ST_IDLE));

    // Priority: enable drop with the 4th sample wins.
    step(1, 0, 0.0);
    for (int i = 0; i < 3; i++) step(1, 1, 2.5e10);
    step(0, 1, 2.5e10);
    check("pr_idle", real'(state_o), real'(ST_IDLE));
    step(0, 0, 0.0);
    check("pr_no_pulse", real'(coef_valid), 0.0);

    // Mid-acquisition reset discards the partial average.
    step(1, 0, 0.0);
    step(1, 1, 3.0e10);
    step(1, 1, 3.0e10);
    do_reset();
    step(1, 0, 0.0);
    for (int i = 0; i < 3; i++) step(1, 1, 1.0e9);
    check("mr_still_acq", real'(state_o), real'(ST_ACQ));
    step(1, 1, 1.0e9);
    check("mr_apply", real'(state_o), real'(ST_APPLY));

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step(($urandom_range(0, 40) != 0), $urandom_range(0, 1) == 1, rand_freq());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
